// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the pipe_stage slice: skid-mode state encoding and
// the default bubble payload.
package pipe_stage_pkg;

    // Occupancy of the stage in skid mode: nothing, output only, output plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

    // Wide enough for any practical payload; instances slice off their WIDTH.
    localparam int                      BUBBLE_MAX_W   = 1024;
    localparam logic [BUBBLE_MAX_W-1:0] BUBBLE_DEFAULT = '0;

    // Entries held for a given skid-mode state.
    function automatic int unsigned occupancy(input stage_state_e s);
        case (s)
            ONE:     return 1;
            TWO:     return 2;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_if.sv
// Valid/ready handshake bundle for pipe_stage: upstream side, downstream side
// and the flush strobe.
interface pipe_stage_if #(
    parameter int WIDTH = 32
) ();
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // The environment around the stage: produces input entries, consumes output.
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The stage itself.
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_sat_counter.sv
// Up-counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // NOTE: sequential state is assigned with <= only, so every flop samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_ONE;
        end
    end
endmodule

// File: rtl/pipe_stage.sv
// One-deep registered pipeline stage with flush, bubble insertion and a stall
// counter. Define PIPE_SKID_EN to add a skid entry and register in_ready.
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = BUBBLE_DEFAULT[WIDTH-1:0],
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_if.slave      bus,
    output logic [CNT_W-1:0] stall_cnt
);
    logic             in_ready;
    logic             accept;
    logic             drain;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;

    assign accept = bus.in_valid && in_ready && !bus.flush;
    assign drain  = out_valid_q && bus.out_ready;

`ifdef PIPE_SKID_EN
    stage_state_e     state;
    logic             in_ready_q;
    logic [WIDTH-1:0] skid_q;
    logic             skid_load;

    // The skid fills only when the output is stuck and a new entry arrives.
    assign skid_load = !rst && !bus.flush && (state == ONE) && accept && !drain;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            out_data_q  <= BUBBLE_VAL;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= bus.in_data;
                    end
                end
                ONE: begin
                    if (accept && !drain) begin
                        state      <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (accept) begin
                        out_data_q <= bus.in_data;
                    end else if (drain) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                        out_data_q  <= BUBBLE_VAL;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state      <= ONE;
                        out_data_q <= skid_q;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    out_data_q  <= BUBBLE_VAL;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: the skid payload has no reset; its contents are meaningful only
    // while state == TWO, so resetting it would buy nothing.
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_q <= bus.in_data;
        end
    end

    assign in_ready = in_ready_q;
`else
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            out_valid_q <= 1'b0;
            out_data_q  <= BUBBLE_VAL;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.in_data;
        end else if (drain) begin
            out_valid_q <= 1'b0;
            out_data_q  <= BUBBLE_VAL;
        end
    end

    // A draining output frees the single slot in the same cycle.
    assign in_ready = !out_valid_q || bus.out_ready;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid_q && !bus.out_ready),
        .count (stall_cnt)
    );
endmodule

// File: tb/tb_pipe_stage.sv
// Directed and randomised checks for pipe_stage in either build (PIPE_SKID_EN
// defined or not); expectations follow the selected build.
module tb_pipe_stage;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] stall_cnt;
    logic [3:0]  sat_cnt;

    always #5 clk = ~clk;

    pipe_stage_if #(.WIDTH(32)) bus  ();
    pipe_stage_if #(.WIDTH(8))  sbus ();

    pipe_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    pipe_stage #(.WIDTH(8), .CNT_W(4)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .bus       (sbus),
        .stall_cnt (sat_cnt)
    );

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [31:0] exp_out_data;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic iv, input logic [31:0] d, input logic ordy);
        bus.flush     = f;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    vec_t        vecs [7];
    logic [31:0] q [$];

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        sbus.flush     = 1'b0;
        sbus.in_valid  = 1'b0;
        sbus.in_data   = 8'h0;
        sbus.out_ready = 1'b0;

        // Reset held for two edges, then released.
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_out_data",  bus.out_data,  32'h0);
        check("reset_stall_cnt", stall_cnt,     16'h0);
        check("reset_in_ready",  bus.in_ready,  1'b1);

        // flush, in_valid, in_data, out_ready | in_ready (pre-edge), out_valid, out_data (post-edge)
        vecs[0] = '{1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 32'h11};
        vecs[1] = '{1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 32'h22};
        vecs[2] = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h33};
        vecs[3] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00};
        vecs[4] = '{1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 1'b0, 32'h00};
        vecs[5] = '{1'b0, 1'b1, 32'h55, 1'b0, 1'b1, 1'b1, 32'h55};
        vecs[6] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00};

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
            #1;
            check($sformatf("vec%0d_in_ready", i), bus.in_ready, vecs[i].exp_in_ready);
            tick();
            check($sformatf("vec%0d_out_valid", i), bus.out_valid, vecs[i].exp_out_valid);
            check($sformatf("vec%0d_out_data", i),  bus.out_data,  vecs[i].exp_out_data);
        end
        check("stream_stall_cnt", stall_cnt, 16'd0);

        // Back-pressure: 0xA5 held for five stalled cycles; 0x5A offered once.
        drive(1'b0, 1'b1, 32'hA5, 1'b0);
        #1;
        check("bp_accept_ready", bus.in_ready, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(1'b0, 1'b1, 32'h5A, 1'b0);
            else        drive(1'b0, 1'b0, 32'h0,  1'b0);
            #1;
            check($sformatf("bp_in_ready_%0d", i), bus.in_ready, (i == 0) ? SKID : 1'b0);
            tick();
            check($sformatf("bp_hold_data_%0d", i), bus.out_data, 32'hA5);
        end
        check("bp_out_valid", bus.out_valid, 1'b1);
        check("bp_stall_cnt", stall_cnt,     16'd5);

        // First drain: the skid entry moves up, otherwise the stage empties.
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        check("drain_in_ready_pre", bus.in_ready, SKID ? 1'b0 : 1'b1);
        tick();
        check("drain_out_valid",  bus.out_valid, SKID);
        check("drain_out_data",   bus.out_data,  SKID ? 32'h5A : 32'h0);
        check("drain_in_ready",   bus.in_ready,  1'b1);
        check("drain_stall_cnt",  stall_cnt,     16'd5);
        tick();
        check("drain_empty", bus.out_valid, 1'b0);

        // Flush while holding 0xA5 (and 0x5A in the skid) with 0x77 offered.
        drive(1'b0, 1'b1, 32'hA5, 1'b0);
        tick();
        drive(1'b0, 1'b1, 32'h5A, 1'b0);
        tick();
        check("pre_flush_data", bus.out_data, 32'hA5);
        drive(1'b1, 1'b1, 32'h77, 1'b1);
        tick();
        check("flush_out_valid", bus.out_valid, 1'b0);
        check("flush_out_data",  bus.out_data,  32'h0);
        check("flush_stall_cnt", stall_cnt,     16'd6);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        check("flush_in_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("flush_stays_empty_%0d", i), bus.out_valid, 1'b0);
        end

        // Saturation on a 4-bit counter.
        sbus.in_valid = 1'b1;
        sbus.in_data  = 8'h3C;
        tick();
        sbus.in_valid = 1'b0;
        repeat (14) tick();
        check("sat_cnt_14", sat_cnt, 4'd14);
        repeat (6) tick();
        check("sat_cnt_15", sat_cnt, 4'd15);
        check("sat_hold_data", sbus.out_data, 8'h3C);
        sbus.out_ready = 1'b1;
        tick();
        check("sat_drained", sbus.out_valid, 1'b0);

        // Random traffic against a FIFO model of the stage contents.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic exp_ir;
            logic ordy;
            logic iv;
            logic [31:0] d;
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            d    = $urandom;
            drive(1'b0, iv, d, ordy);
            #1;
            exp_ir = SKID ? (q.size() < 2) : ((q.size() == 0) || ordy);
            check("rnd_in_ready",  bus.in_ready,  exp_ir);
            check("rnd_out_valid", bus.out_valid, q.size() != 0);
            if (q.size() != 0) begin
                check("rnd_out_data", bus.out_data, q[0]);
                if (ordy) void'(q.pop_front());
            end
            if (iv && exp_ir) q.push_back(d);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter BUBBLE_VAL, default all-zero WIDTH bits, payload value driven when the stage holds no valid entry.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  discard all held and incoming entries this cycle.
REQ-007 SHALL have port in_valid  input  1  upstream entry present.
REQ-008 SHALL have port in_ready  output  1  stage accepts an entry this cycle.
REQ-009 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-010 SHALL have port out_valid  output  1  downstream entry present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the entry this cycle.
REQ-012 SHALL have port out_data  output  WIDTH  payload, registered.
REQ-013 SHALL have port stall_cnt  output  CNT_W  count of back-pressured cycles.

Function
REQ-014 SHALL accept an entry iff in_valid && in_ready && !flush (accept event).
REQ-015 SHALL complete a transfer iff out_valid && out_ready (drain event).
REQ-016 SHALL present an accepted entry on out_data/out_valid exactly one cycle after the accept when the output register is empty or draining; latency SHALL be 1 cycle.
REQ-017 SHALL preserve entry order; no entry is duplicated or dropped except by flush.
REQ-018 SHALL load BUBBLE_VAL into out_data whenever out_valid falls to 0 (drain with no replacement, or flush).
REQ-019 SHALL keep out_data and out_valid stable while out_valid && !out_ready.
REQ-020 On flush, SHALL clear out_valid, load BUBBLE_VAL into out_data, empty every internal entry and ignore in_valid that cycle; flush SHALL override simultaneous accept and drain.
REQ-021 SHALL increment stall_cnt by 1 in each cycle with out_valid && !out_ready, saturating at 2^CNT_W-1; flush SHALL NOT clear it.
REQ-022 SHALL sustain one accept and one drain per cycle indefinitely when in_valid and out_ready are both held high.

Reset
REQ-023 On rst, SHALL set out_valid=0, out_data=BUBBLE_VAL, stall_cnt=0 and empty all internal entries on the next edge.
REQ-024 rst SHALL take priority over flush, accept and drain; an entry mid-transfer at reset SHALL be lost.
REQ-025 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-026 With macro PIPE_SKID_EN defined, SHALL include a one-entry skid register; states EMPTY, ONE (output full), TWO (output plus skid full).
REQ-027 With PIPE_SKID_EN, in_ready SHALL be a register output equal to (state != TWO), with no combinational path from out_ready.
REQ-028 With PIPE_SKID_EN, transitions SHALL be: EMPTY->ONE on accept; ONE->TWO on accept without drain; ONE->EMPTY on drain without accept; TWO->ONE on drain, with skid moving to output; any state->EMPTY on flush or rst.
REQ-029 Without PIPE_SKID_EN, SHALL hold a single entry and drive in_ready = !out_valid || out_ready combinationally.

Structure
REQ-030 The shared package SHALL hold the state encoding constants (EMPTY, ONE, TWO) and the default BUBBLE_VAL constant.
REQ-031 The saturating stall counter SHALL be the sub-module sat_counter with a CNT_W parameter.

Verification
REQ-032 Reset: assert rst 2 cycles, then release -> out_valid=0, out_data=0, stall_cnt=0, in_ready=1.
REQ-033 Streaming: send 0x11,0x22,0x33 on consecutive cycles with out_ready=1 -> the same values appear in order on out_data, each 1 cycle after its accept, with no gaps.
REQ-034 Back-pressure: send 0xA5, hold out_ready=0 for 5 cycles -> out_data stays 0xA5 and stall_cnt=5; with skid, a second entry 0x5A is accepted and then in_ready=0 until the first drain.
REQ-035 Flush: with the stage holding 0xA5 (skid 0x5A) and in_valid=1 carrying 0x77, pulse flush -> next cycle out_valid=0, out_data=0, 0x77 never appears, stall_cnt unchanged.
REQ-036 Saturation: CNT_W=4, back-pressure 20 cycles -> stall_cnt stops at 15.
REQ-037 Random: randomised in_valid/out_ready over 10000 cycles, both macro settings -> output sequence equals accepted sequence and the one-entry / two-entry capacity is never exceeded.
